// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the uart_rx_baud receiver:
//     - uart_state_e : receive FSM states (IDLE, START, DATA, STOP)
//     - calc_div     : clocks per oversample tick, rounded to nearest
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks per tick at 4x oversampling; adding half a tick period rounds to nearest
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud * 32'd2) / (baud * 32'd4);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Free-running divider producing a one-clock tick every DIV clocks.
//   The counter runs 0..DIV-1; tick is high while the count equals DIV-1.
//   Ports:
//     clk    in  system clock
//     resetn in  asynchronous active-low reset
//     tick   out one-clock pulse (registered)
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned DIV = 109
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    // tick is registered, so it is raised one count early to line up with DIV-1
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and early tick decode
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_q == CNT_PRE) begin
            tick_d = 1'b1;
        end else begin
            tick_d = 1'b0;
        end
    end

    // Divider state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_baud.sv
// ---------------------------------------------------------------------------
// uart_rx_baud
//   8N1 UART receiver (idle high, LSB first) with built-in 4x oversample
//   tick generator. Each received byte is presented on rx_byte with a
//   one-clock rdy pulse; 0xFF is delivered like any other byte.
//   Optional feature macro: UART_RX_FRAMING_ERR_EN
//     defined   : frame_err port; bad stop bit pulses frame_err, no rdy,
//                 and the receiver waits for idle-high before re-arming.
//     undefined : bad stop bit still delivers the byte with rdy.
//   Ports:
//     clk       in  system clock
//     resetn    in  asynchronous active-low reset
//     rx        in  serial input (asynchronous, idles high)
//     tick      out one-clock pulse at BAUD*4
//     rx_byte   out last received byte, stable until the next rdy
//     rdy       out one-clock pulse, rx_byte valid
//     frame_err out one-clock pulse on bad stop bit (macro only)
// ---------------------------------------------------------------------------
module uart_rx_baud
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic       tick,
    output logic [7:0] rx_byte,
    output logic       rdy
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    // Sub-count at which the middle of a bit is reached
    localparam logic [1:0] SCNT_MID  = 2'(OVERSAMPLE / 2 - 1);
    localparam logic [1:0] SCNT_LAST = 2'(OVERSAMPLE - 1);

    logic        tick_s;
    logic        sync1_q, sync2_q;
    logic        rx_s;
    logic        armed_s;
    uart_state_e state_q, state_d;
    logic [1:0]  scnt_q, scnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rdy_q, rdy_d;
`ifdef UART_RX_FRAMING_ERR_EN
    logic        frame_err_q, frame_err_d;
    logic        armed_q, armed_d;
    assign armed_s = armed_q;
`else
    assign armed_s = 1'b1;
`endif

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick_s)
    );

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Receive FSM next-state logic; advances only on tick cycles
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        rdy_d     = 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
        frame_err_d = 1'b0;
        armed_d     = armed_q;
`endif
        if (tick_s) begin
            case (state_q)
                IDLE: begin
`ifdef UART_RX_FRAMING_ERR_EN
                    // After a framing error the line must return high first
                    if (!armed_q) begin
                        armed_d = rx_s;
                    end else begin
                        armed_d = 1'b1;
                    end
`endif
                    if (!rx_s && armed_s) begin
                        state_d = START;
                        scnt_d  = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (scnt_q == SCNT_MID) begin
                        // Mid start bit: a high line means the edge was a glitch
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_idx_d = 3'd0;
                        end
                        scnt_d = 2'd0;
                    end else begin
                        scnt_d = scnt_q + 2'd1;
                    end
                end
                DATA: begin
                    if (scnt_q == SCNT_LAST) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        scnt_d  = 2'd0;
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        scnt_d = scnt_q + 2'd1;
                    end
                end
                STOP: begin
                    if (scnt_q == SCNT_LAST) begin
                        // Return to IDLE at mid-stop so a following start edge is not missed
                        state_d = IDLE;
                        scnt_d  = 2'd0;
                        if (rx_s) begin
                            rx_byte_d = shift_q;
                            rdy_d     = 1'b1;
                        end else begin
`ifdef UART_RX_FRAMING_ERR_EN
                            frame_err_d = 1'b1;
                            armed_d     = 1'b0;
`else
                            rx_byte_d = shift_q;
                            rdy_d     = 1'b1;
`endif
                        end
                    end else begin
                        scnt_d = scnt_q + 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    scnt_d  = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receive FSM and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            scnt_q    <= 2'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            rx_byte_q <= 8'h00;
            rdy_q     <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
            frame_err_q <= 1'b0;
            armed_q     <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            rdy_q     <= rdy_d;
`ifdef UART_RX_FRAMING_ERR_EN
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
`endif
        end
    end

    assign tick    = tick_s;
    assign rx_byte = rx_byte_q;
    assign rdy     = rdy_q;
`ifdef UART_RX_FRAMING_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_baud.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_baud
//   Directed self-checking bench for uart_rx_baud at the default parameters
//   (109 clk per tick, 434 clk per transmitted bit).
// ---------------------------------------------------------------------------
module tb_uart_rx_baud;
    import uart_pkg::*;

    localparam int BIT_CLKS = 434;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       rx     = 1'b1;
    logic       tick;
    logic [7:0] rx_byte;
    logic       rdy;
`ifdef UART_RX_FRAMING_ERR_EN
    logic       frame_err;
`endif

    int errors = 0;
    int checks = 0;

    // Monitor state
    int         rdy_cnt  = 0;
    int         ferr_cnt = 0;
    int         dbl_cnt  = 0;
    logic       prev_rdy = 1'b0;
    logic [7:0] byte_log [16];

    uart_rx_baud dut (
        .clk     (clk),
        .resetn  (resetn),
        .rx      (rx),
        .tick    (tick),
        .rx_byte (rx_byte),
        .rdy     (rdy)
`ifdef UART_RX_FRAMING_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #10 clk = ~clk;

    // Record every rdy pulse and its byte, sampled away from the active edge
    always @(negedge clk) begin
        if (rdy) begin
            byte_log[rdy_cnt[3:0]] <= rx_byte;
            rdy_cnt <= rdy_cnt + 1;
        end
        if (rdy && prev_rdy) begin
            dbl_cnt <= dbl_cnt + 1;
        end
        prev_rdy <= rdy;
`ifdef UART_RX_FRAMING_ERR_EN
        if (frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
        end
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        send_bit(stop_v);
        rx = 1'b1;
    endtask

    initial begin
        int n;
        int c0;
        int f0;

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_rdy", 32'(rdy), 32'd0);
        check_eq("rst_rx_byte", 32'(rx_byte), 32'h00);
`ifdef UART_RX_FRAMING_ERR_EN
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
`endif

        // Tick timing: first at 108 clocks after release, then every 109
        @(negedge clk);
        resetn = 1'b1;
        n = 300;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                n = k;
                break;
            end
        end
        check_eq("tick_first", 32'(n), 32'd108);
        for (int p = 0; p < 2; p++) begin
            @(posedge clk);
            #1;
            check_eq("tick_one_clk", 32'(tick), 32'd0);
            n = 300;
            for (int k = 2; k <= 300; k++) begin
                @(posedge clk);
                #1;
                if (tick) begin
                    n = k;
                    break;
                end
            end
            check_eq("tick_period", 32'(n), 32'd109);
        end

        // Single frame 0x41
        repeat (2 * BIT_CLKS) @(posedge clk);
        c0 = rdy_cnt;
        send_frame(8'h41, 1'b1);
        repeat (200) @(posedge clk);
        check_eq("rdy_cnt_41", 32'(rdy_cnt - c0), 32'd1);
        check_eq("byte_41", 32'(byte_log[c0[3:0]]), 32'h41);
        check_eq("rx_byte_held_41", 32'(rx_byte), 32'h41);

        // Back-to-back 0x55, 0xAA with a single stop bit between
        c0 = rdy_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        repeat (200) @(posedge clk);
        check_eq("rdy_cnt_b2b", 32'(rdy_cnt - c0), 32'd2);
        check_eq("byte_b2b_0", 32'(byte_log[c0[3:0]]), 32'h55);
        c0 = c0 + 1;
        check_eq("byte_b2b_1", 32'(byte_log[c0[3:0]]), 32'hAA);

        // 0xFF passes through unchanged
        c0 = rdy_cnt;
        send_frame(8'hFF, 1'b1);
        repeat (200) @(posedge clk);
        check_eq("rdy_cnt_ff", 32'(rdy_cnt - c0), 32'd1);
        check_eq("byte_ff", 32'(byte_log[c0[3:0]]), 32'hFF);

        // Short low pulse is rejected as a glitch
        c0 = rdy_cnt;
        rx = 1'b0;
        repeat (150) @(posedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(posedge clk);
        check_eq("rdy_cnt_glitch", 32'(rdy_cnt - c0), 32'd0);
        check_eq("idle_after_glitch", 32'(dut.state_q), 32'(IDLE));

        // Bad stop bit on 0x3C
        c0 = rdy_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (3 * BIT_CLKS) @(posedge clk);
`ifdef UART_RX_FRAMING_ERR_EN
        check_eq("ferr_cnt_3c", 32'(ferr_cnt - f0), 32'd1);
        check_eq("rdy_cnt_3c", 32'(rdy_cnt - c0), 32'd0);
        check_eq("rx_byte_kept_3c", 32'(rx_byte), 32'hFF);
`else
        check_eq("ferr_cnt_3c", 32'(ferr_cnt - f0), 32'd0);
        check_eq("rdy_cnt_3c", 32'(rdy_cnt - c0), 32'd1);
        check_eq("byte_3c", 32'(byte_log[c0[3:0]]), 32'h3C);
`endif
        check_eq("idle_after_3c", 32'(dut.state_q), 32'(IDLE));

        // Reset in the middle of bit 4, then a clean 0x7E
        c0 = rdy_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(i[0]);
        end
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        resetn = 1'b0;
        #1;
        check_eq("midrst_tick", 32'(tick), 32'd0);
        check_eq("midrst_rdy", 32'(rdy), 32'd0);
        check_eq("midrst_rx_byte", 32'(rx_byte), 32'h00);
`ifdef UART_RX_FRAMING_ERR_EN
        check_eq("midrst_frame_err", 32'(frame_err), 32'd0);
`endif
        repeat (20) @(posedge clk);
        check_eq("midrst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        resetn = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        check_eq("rdy_cnt_aborted", 32'(rdy_cnt - c0), 32'd0);
        send_frame(8'h7E, 1'b1);
        repeat (200) @(posedge clk);
        check_eq("rdy_cnt_7e", 32'(rdy_cnt - c0), 32'd1);
        check_eq("byte_7e", 32'(byte_log[c0[3:0]]), 32'h7E);

        check_eq("no_double_rdy", 32'(dbl_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
